// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding.
// Registered decode fields feed a zero-latency forwarding mux in front of the ALU.
module id_ex_stage #(
  parameter int DATAWIDTH = 32,
  parameter int REGW      = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic                 valid_i,
  input  logic [DATAWIDTH-1:0] RD1_i,
  input  logic [DATAWIDTH-1:0] RD2_i,
  input  logic [DATAWIDTH-1:0] ImmExt_i,
  input  logic [DATAWIDTH-1:0] PC_i,
  input  logic [REGW-1:0]      Rs1_i,
  input  logic [REGW-1:0]      Rs2_i,
  input  logic [REGW-1:0]      Rd_i,
  input  logic [3:0]           ALUctrl_i,
  input  logic [2:0]           BranchCtrl_i,
  input  logic                 ALUSrcA_i,
  input  logic                 ALUSrcB_i,
  input  logic                 RegWrite_i,
  input  logic                 ExMemRegWrite_i,
  input  logic [REGW-1:0]      ExMemRd_i,
  input  logic [DATAWIDTH-1:0] ExMemResult_i,
  input  logic                 MemWbRegWrite_i,
  input  logic [REGW-1:0]      MemWbRd_i,
  input  logic [DATAWIDTH-1:0] MemWbResult_i,
  output logic [DATAWIDTH-1:0] SrcA_o,
  output logic [DATAWIDTH-1:0] SrcB_o,
  output logic [DATAWIDTH-1:0] StoreData_o,
  output logic [3:0]           ALUctrl_o,
  output logic [2:0]           BranchCtrl_o,
  output logic [DATAWIDTH-1:0] PC_o,
  output logic [REGW-1:0]      Rd_o,
  output logic                 RegWrite_o,
  output logic                 valid_o
);

  logic                 valid_q, valid_d;
  logic                 regwrite_q, regwrite_d;
  logic [2:0]           branch_q, branch_d;
  logic [3:0]           aluctrl_q, aluctrl_d;
  logic [DATAWIDTH-1:0] pc_q, pc_d;
  logic [DATAWIDTH-1:0] rd1_q, rd1_d;
  logic [DATAWIDTH-1:0] rd2_q, rd2_d;
  logic [DATAWIDTH-1:0] imm_q, imm_d;
  logic [REGW-1:0]      rs1_q, rs1_d;
  logic [REGW-1:0]      rs2_q, rs2_d;
  logic [REGW-1:0]      rd_q, rd_d;
  logic                 srca_sel_q, srca_sel_d;
  logic                 srcb_sel_q, srcb_sel_d;
  logic [DATAWIDTH-1:0] fwd_a, fwd_b;

  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    branch_d   = branch_q;
    aluctrl_d  = aluctrl_q;
    pc_d       = pc_q;
    rd1_d      = rd1_q;
    rd2_d      = rd2_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    srca_sel_d = srca_sel_q;
    srcb_sel_d = srcb_sel_q;
    // A flush only kills the side-effecting fields; datapath fields are left as-is.
    if (flush_i) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      branch_d   = 3'b000;
    end else if (!stall_i) begin
      valid_d    = valid_i;
      regwrite_d = RegWrite_i & valid_i;
      branch_d   = valid_i ? BranchCtrl_i : 3'b000;
      aluctrl_d  = ALUctrl_i;
      pc_d       = PC_i;
      rd1_d      = RD1_i;
      rd2_d      = RD2_i;
      imm_d      = ImmExt_i;
      rs1_d      = Rs1_i;
      rs2_d      = Rs2_i;
      rd_d       = Rd_i;
      srca_sel_d = ALUSrcA_i;
      srcb_sel_d = ALUSrcB_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      branch_q   <= '0;
      aluctrl_q  <= '0;
      pc_q       <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      srca_sel_q <= 1'b0;
      srcb_sel_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      branch_q   <= branch_d;
      aluctrl_q  <= aluctrl_d;
      pc_q       <= pc_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      srca_sel_q <= srca_sel_d;
      srcb_sel_q <= srcb_sel_d;
    end
  end

  // EX/MEM is the younger producer, so it wins; x0 is hardwired and never forwarded.
  always_comb begin
    fwd_a = rd1_q;
    if (ExMemRegWrite_i && (ExMemRd_i != '0) && (ExMemRd_i == rs1_q))
      fwd_a = ExMemResult_i;
    else if (MemWbRegWrite_i && (MemWbRd_i != '0) && (MemWbRd_i == rs1_q))
      fwd_a = MemWbResult_i;
  end

  always_comb begin
    fwd_b = rd2_q;
    if (ExMemRegWrite_i && (ExMemRd_i != '0) && (ExMemRd_i == rs2_q))
      fwd_b = ExMemResult_i;
    else if (MemWbRegWrite_i && (MemWbRd_i != '0) && (MemWbRd_i == rs2_q))
      fwd_b = MemWbResult_i;
  end

  assign SrcA_o       = srca_sel_q ? pc_q : fwd_a;
  assign SrcB_o       = srcb_sel_q ? imm_q : fwd_b;
  assign StoreData_o  = fwd_b;
  assign ALUctrl_o    = aluctrl_q;
  assign BranchCtrl_o = branch_q;
  assign PC_o         = pc_q;
  assign Rd_o         = rd_q;
  assign RegWrite_o   = regwrite_q;
  assign valid_o      = valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic against an
// entry-level reference model of the stage.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, stall_i, flush_i, valid_i;
  logic [31:0] RD1_i, RD2_i, ImmExt_i, PC_i;
  logic [4:0]  Rs1_i, Rs2_i, Rd_i;
  logic [3:0]  ALUctrl_i;
  logic [2:0]  BranchCtrl_i;
  logic        ALUSrcA_i, ALUSrcB_i, RegWrite_i;
  logic        ExMemRegWrite_i, MemWbRegWrite_i;
  logic [4:0]  ExMemRd_i, MemWbRd_i;
  logic [31:0] ExMemResult_i, MemWbResult_i;
  logic [31:0] SrcA_o, SrcB_o, StoreData_o, PC_o;
  logic [3:0]  ALUctrl_o;
  logic [2:0]  BranchCtrl_o;
  logic [4:0]  Rd_o;
  logic        RegWrite_o, valid_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATAWIDTH(32), .REGW(5)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .RD1_i(RD1_i), .RD2_i(RD2_i), .ImmExt_i(ImmExt_i), .PC_i(PC_i),
    .Rs1_i(Rs1_i), .Rs2_i(Rs2_i), .Rd_i(Rd_i), .ALUctrl_i(ALUctrl_i),
    .BranchCtrl_i(BranchCtrl_i), .ALUSrcA_i(ALUSrcA_i), .ALUSrcB_i(ALUSrcB_i),
    .RegWrite_i(RegWrite_i),
    .ExMemRegWrite_i(ExMemRegWrite_i), .ExMemRd_i(ExMemRd_i), .ExMemResult_i(ExMemResult_i),
    .MemWbRegWrite_i(MemWbRegWrite_i), .MemWbRd_i(MemWbRd_i), .MemWbResult_i(MemWbResult_i),
    .SrcA_o(SrcA_o), .SrcB_o(SrcB_o), .StoreData_o(StoreData_o), .ALUctrl_o(ALUctrl_o),
    .BranchCtrl_o(BranchCtrl_o), .PC_o(PC_o), .Rd_o(Rd_o), .RegWrite_o(RegWrite_o),
    .valid_o(valid_o)
  );

  // Model of the instruction held in the stage; 'known' drops after a flush,
  // since a flushed entry's datapath fields are don't-care.
  typedef struct {
    logic        valid, regwrite, known, sel_a, sel_b;
    logic [2:0]  br;
    logic [3:0]  alu;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] pc, rd1, rd2, imm;
  } entry_t;

  entry_t m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] regv);
    if (rs == 5'd0) return regv;
    if (ExMemRegWrite_i && ExMemRd_i == rs) return ExMemResult_i;
    if (MemWbRegWrite_i && MemWbRd_i == rs) return MemWbResult_i;
    return regv;
  endfunction

  task automatic model_update();
    if (rst) begin
      m = '{default: '0};
      m.known = 1'b1;
    end else if (flush_i) begin
      m.valid = 1'b0; m.regwrite = 1'b0; m.br = 3'b000; m.known = 1'b0;
    end else if (!stall_i) begin
      m.valid = valid_i;
      m.regwrite = valid_i && RegWrite_i;
      m.br = valid_i ? BranchCtrl_i : 3'b000;
      m.alu = ALUctrl_i; m.pc = PC_i; m.rd1 = RD1_i; m.rd2 = RD2_i; m.imm = ImmExt_i;
      m.rs1 = Rs1_i; m.rs2 = Rs2_i; m.rd = Rd_i; m.sel_a = ALUSrcA_i; m.sel_b = ALUSrcB_i;
      m.known = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("valid", 32'(valid_o), 32'(m.valid));
    chk("regwrite", 32'(RegWrite_o), 32'(m.regwrite));
    chk("branch", 32'(BranchCtrl_o), 32'(m.br));
    if (m.known) begin
      chk("aluctrl", 32'(ALUctrl_o), 32'(m.alu));
      chk("pc", PC_o, m.pc);
      chk("rd", 32'(Rd_o), 32'(m.rd));
      chk("srca", SrcA_o, m.sel_a ? m.pc : fwd(m.rs1, m.rd1));
      chk("srcb", SrcB_o, m.sel_b ? m.imm : fwd(m.rs2, m.rd2));
      chk("store", StoreData_o, fwd(m.rs2, m.rd2));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic clear_inputs();
    rst = 0; stall_i = 0; flush_i = 0; valid_i = 0;
    RD1_i = 0; RD2_i = 0; ImmExt_i = 0; PC_i = 0;
    Rs1_i = 0; Rs2_i = 0; Rd_i = 0; ALUctrl_i = 0; BranchCtrl_i = 0;
    ALUSrcA_i = 0; ALUSrcB_i = 0; RegWrite_i = 0;
    ExMemRegWrite_i = 0; ExMemRd_i = 0; ExMemResult_i = 0;
    MemWbRegWrite_i = 0; MemWbRd_i = 0; MemWbResult_i = 0;
  endtask

  initial begin
    m = '{default: '0};
    clear_inputs();

    // Reset with busy inputs
    rst = 1; valid_i = 1; RegWrite_i = 1; BranchCtrl_i = 3'b101; ALUctrl_i = 4'h9;
    PC_i = 32'h1234; RD1_i = 32'h77; Rd_i = 5'd4;
    step();
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_regwrite", 32'(RegWrite_o), 32'd0);
    chk("rst_branch", 32'(BranchCtrl_o), 32'd0);
    chk("rst_aluctrl", 32'(ALUctrl_o), 32'd0);
    chk("rst_pc", PC_o, 32'd0);

    // Plain load
    clear_inputs();
    RD1_i = 32'd5; RD2_i = 32'd7; valid_i = 1; RegWrite_i = 1; Rs1_i = 5'd1; Rs2_i = 5'd2;
    step();
    chk("load_srca", SrcA_o, 32'd5);
    chk("load_srcb", SrcB_o, 32'd7);
    chk("load_regwrite", 32'(RegWrite_o), 32'd1);

    // Forwarding priority
    Rs1_i = 5'd3; RD1_i = 32'h11;
    ExMemRegWrite_i = 1; ExMemRd_i = 5'd3; ExMemResult_i = 32'hAA;
    MemWbRegWrite_i = 1; MemWbRd_i = 5'd3; MemWbResult_i = 32'hBB;
    step();
    chk("fwd_exmem", SrcA_o, 32'hAA);
    ExMemRegWrite_i = 0; #1;
    chk("fwd_memwb", SrcA_o, 32'hBB);
    Rs1_i = 5'd0; ExMemRegWrite_i = 1; ExMemRd_i = 5'd0; MemWbRd_i = 5'd0;
    step();
    chk("fwd_x0", SrcA_o, 32'h11);

    // Immediate / PC select with forwarded store data
    clear_inputs();
    valid_i = 1; ALUSrcA_i = 1; ALUSrcB_i = 1; PC_i = 32'h100; ImmExt_i = 32'hFFFF_FFFC;
    Rs2_i = 5'd6; RD2_i = 32'h9; ExMemRegWrite_i = 1; ExMemRd_i = 5'd6; ExMemResult_i = 32'h55;
    step();
    chk("sel_srca", SrcA_o, 32'h100);
    chk("sel_srcb", SrcB_o, 32'hFFFF_FFFC);
    chk("sel_store", StoreData_o, 32'h55);

    // Stall with live forwarding
    clear_inputs();
    valid_i = 1; RegWrite_i = 1; Rs1_i = 5'd4; RD1_i = 32'h40; PC_i = 32'h200; Rd_i = 5'd8;
    step();
    stall_i = 1; PC_i = 32'h300; Rs1_i = 5'd9; valid_i = 0;
    ExMemRegWrite_i = 1; ExMemRd_i = 5'd4;
    for (int i = 1; i <= 3; i++) begin
      ExMemResult_i = i;
      step();
      chk("stall_srca", SrcA_o, i);
      chk("stall_pc", PC_o, 32'h200);
      chk("stall_valid", 32'(valid_o), 32'd1);
    end

    // Flush during stall on a valid branch
    clear_inputs();
    valid_i = 1; RegWrite_i = 1; BranchCtrl_i = 3'b001;
    step();
    chk("br_loaded", 32'(BranchCtrl_o), 32'd1);
    stall_i = 1; flush_i = 1;
    step();
    chk("flush_valid", 32'(valid_o), 32'd0);
    chk("flush_regwrite", 32'(RegWrite_o), 32'd0);
    chk("flush_branch", 32'(BranchCtrl_o), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 99) < 3);
      flush_i  = ($urandom_range(0, 99) < 10);
      stall_i  = ($urandom_range(0, 99) < 25);
      valid_i  = ($urandom_range(0, 99) < 75);
      RD1_i = $urandom; RD2_i = $urandom; ImmExt_i = $urandom; PC_i = $urandom;
      Rs1_i = 5'($urandom_range(0, 3)); Rs2_i = 5'($urandom_range(0, 3));
      Rd_i = 5'($urandom_range(0, 31)); ALUctrl_i = 4'($urandom_range(0, 15));
      BranchCtrl_i = 3'($urandom_range(0, 7));
      ALUSrcA_i = 1'($urandom_range(0, 1)); ALUSrcB_i = 1'($urandom_range(0, 1));
      RegWrite_i = 1'($urandom_range(0, 1));
      ExMemRegWrite_i = 1'($urandom_range(0, 1)); ExMemRd_i = 5'($urandom_range(0, 3));
      ExMemResult_i = $urandom;
      MemWbRegWrite_i = 1'($urandom_range(0, 1)); MemWbRd_i = 5'($urandom_range(0, 3));
      MemWbResult_i = $urandom;
      step();
      ExMemRegWrite_i = 1'($urandom_range(0, 1)); ExMemRd_i = 5'($urandom_range(0, 3));
      ExMemResult_i = $urandom;
      MemWbRegWrite_i = 1'($urandom_range(0, 1)); MemWbRd_i = 5'($urandom_range(0, 3));
      MemWbResult_i = $urandom;
      #1;
      check_all();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
